waterfall_ctrl: RTL and testbench

- Sequencer for the 8-bit waterfall-light pattern path.
- Holds the current LED pattern and advances it once per prescaled step, using one of four shift/rotate modes.
- Provides start, pause and clear control.
- Sits between the board switches/buttons and the LED outputs. It replaces free-running combinational shift/rotate selection with a timed, stateful controller.

---
 rtl/waterfall_ctrl_pkg.sv | 22 ++
 rtl/waterfall_ctrl_if.sv | 17 +
 rtl/waterfall_prescaler.sv | 28 ++
 rtl/waterfall_ctrl.sv | 109 ++++++++++
 tb/tb_waterfall_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/waterfall_ctrl_pkg.sv
// Shared constants and debug types for the waterfall LED sequencer.
// Holds the state encodings, step modes and ping-pong direction values.
package waterfall_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  localparam logic [1:0] M_ROR  = 2'd0;
  localparam logic [1:0] M_ROL  = 2'd1;
  localparam logic [1:0] M_JOHN = 2'd2;
  localparam logic [1:0] M_PING = 2'd3;

  localparam logic DIR_R = 1'b0;
  localparam logic DIR_L = 1'b1;

  typedef struct packed {
    logic [1:0] state;
    logic       dir;
  } dbg_t;

endpackage

// File: rtl/waterfall_ctrl_if.sv
// Control and LED bundle between the board switches/buttons and the sequencer.
// Controls are level signals: en runs or resumes the sequence, clr forces IDLE.
interface waterfall_ctrl_if;
  import waterfall_ctrl_pkg::*;

  logic       en;
  logic       clr;
  logic [1:0] mode;
  logic [7:0] seed;
  logic [7:0] led;
  logic       step;
  logic       busy;
  dbg_t       dbg;

  modport master (output en, clr, mode, seed, input led, step, busy, dbg);
  modport slave  (input en, clr, mode, seed, output led, step, busy, dbg);
endinterface

// File: rtl/waterfall_prescaler.sv
// Step prescaler: counts enabled cycles and flags the last count of each step.
// cnt is held while en is low, so paused cycles do not count.
module waterfall_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + W'(1);
    end
  end
endmodule

// File: rtl/waterfall_ctrl.sv
// Timed waterfall-light sequencer: holds the LED pattern and advances it once
// per prescaled step using rotate, Johnson or ping-pong stepping.
module waterfall_ctrl
  import waterfall_ctrl_pkg::*;
#(
  parameter int         DIV      = 25_000_000,
  parameter logic [7:0] INIT_PAT = 8'b1000_0000
) (
  input  logic             clk,
  input  logic             rst,
  waterfall_ctrl_if.slave  bus
);
  logic [1:0] state;
  logic [7:0] pat;
  logic       dir;
  logic       step_r;
  logic       tick;
  logic       adv;
  logic [7:0] nxt_pat;
  logic       nxt_dir;

  // clr outranks a due step, so it also gates the counter advance.
  assign adv = (state == ST_RUN) && bus.en && !bus.clr;

  waterfall_prescaler #(.DIV(DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (adv),
    .clr  (bus.clr || (state == ST_IDLE)),
    .tick (tick)
  );

  always_comb begin
    nxt_pat = pat;
    nxt_dir = dir;
    case (bus.mode)
      M_ROR:  nxt_pat = {pat[0], pat[7:1]};
      M_ROL:  nxt_pat = {pat[6:0], pat[7]};
      M_JOHN: nxt_pat = {~pat[0], pat[7:1]};
      default: begin
        // Ping-pong bounces off bit 0 and bit 7; an empty pattern restarts.
        if (pat == 8'h00) begin
          nxt_pat = INIT_PAT;
          nxt_dir = DIR_R;
        end else if (dir == DIR_R) begin
          if (pat[0]) begin
            nxt_pat = pat << 1;
            nxt_dir = DIR_L;
          end else begin
            nxt_pat = pat >> 1;
          end
        end else begin
          if (pat[7]) begin
            nxt_pat = pat >> 1;
            nxt_dir = DIR_R;
          end else begin
            nxt_pat = pat << 1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      pat    <= 8'h00;
      dir    <= DIR_R;
      step_r <= 1'b0;
    end else begin
      step_r <= 1'b0;
      if (bus.clr) begin
        state <= ST_IDLE;
        pat   <= 8'h00;
        dir   <= DIR_R;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.en) begin
              state <= ST_RUN;
              pat   <= (bus.seed == 8'h00) ? INIT_PAT : bus.seed;
              dir   <= DIR_R;
            end
          end
          ST_RUN: begin
            if (!bus.en) begin
              state <= ST_PAUSE;
            end else if (tick) begin
              pat    <= nxt_pat;
              dir    <= nxt_dir;
              step_r <= 1'b1;
            end
          end
          ST_PAUSE: begin
            if (bus.en) state <= ST_RUN;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // pat is cleared on every IDLE entry, so it already reads 0 while idle.
  assign bus.led       = pat;
  assign bus.step      = step_r;
  assign bus.busy      = (state == ST_RUN) || (state == ST_PAUSE);
  assign bus.dbg.state = state;
  assign bus.dbg.dir   = dir;
endmodule

// File: tb/tb_waterfall_ctrl.sv
// Bench for waterfall_ctrl: scenario tasks with a scoreboard of expected LED
// steps, checked against step pulses and step spacing.
module tb_waterfall_ctrl;
  import waterfall_ctrl_pkg::*;

  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst;

  waterfall_ctrl_if bus();

  waterfall_ctrl #(.DIV(DIV), .INIT_PAT(8'h80)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] exp_q[$];
  logic       exp_dir_q[$];
  int tests = 0;
  int fails = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] model_next(input logic [7:0] p, input logic [1:0] m, input logic d);
    logic [7:0] q;
    logic       nd;
    q  = p;
    nd = d;
    case (m)
      2'd0: q = (p >> 1) | (p << 7);
      2'd1: q = (p << 1) | (p >> 7);
      2'd2: q = (p >> 1) | (p[0] ? 8'h00 : 8'h80);
      default: begin
        if (p == 8'h00) begin
          q = 8'h80; nd = 1'b0;
        end else if (!d) begin
          if (p[0]) begin q = p << 1; nd = 1'b1; end
          else q = p >> 1;
        end else begin
          if (p[7]) begin q = p >> 1; nd = 1'b0; end
          else q = p << 1;
        end
      end
    endcase
    return {nd, q};
  endfunction

  task automatic push_model(input logic [7:0] p0, input logic [1:0] m, input int n);
    logic [7:0] p;
    logic       d;
    logic [8:0] r;
    p = p0;
    d = 1'b0;
    for (int i = 0; i < n; i++) begin
      r = model_next(p, m, d);
      p = r[7:0];
      d = r[8];
      exp_q.push_back(p);
    end
  endtask

  task automatic start(input logic [7:0] s, input logic [1:0] m);
    bus.seed = s;
    bus.mode = m;
    bus.clr  = 1'b0;
    bus.en   = 1'b1;
    cyc();
  endtask

  task automatic stop();
    bus.en  = 1'b0;
    bus.clr = 1'b1;
    cyc();
    bus.clr = 1'b0;
    cyc();
  endtask

  // Pops one expected value per step pulse; also checks spacing of DIV cycles.
  task automatic drain(input string name, input int budget, input int since0);
    int since;
    logic [7:0] e;
    logic ed;
    since = since0;
    while (exp_q.size() > 0 && budget > 0) begin
      cyc();
      budget--;
      since++;
      if (bus.step === 1'b1) begin
        e = exp_q.pop_front();
        tests++;
        if (bus.led !== e) begin
          fails++;
          $display("FAIL %s led: got %h expected %h", name, bus.led, e);
        end
        tests++;
        if (since !== DIV) begin
          fails++;
          $display("FAIL %s step spacing: got %0d expected %0d", name, since, DIV);
        end
        tests++;
        if (bus.busy !== 1'b1) begin
          fails++;
          $display("FAIL %s busy: got %b expected 1", name, bus.busy);
        end
        if (exp_dir_q.size() > 0) begin
          ed = exp_dir_q.pop_front();
          tests++;
          if (bus.dbg.dir !== ed) begin
            fails++;
            $display("FAIL %s dir after led %h: got %b expected %b", name, e, bus.dbg.dir, ed);
          end
        end
        since = 0;
      end
    end
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: %0d steps missing", name, exp_q.size());
      exp_q.delete();
      exp_dir_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b0; bus.clr = 1'b0; bus.mode = 2'd0; bus.seed = 8'h00;
    cyc(); cyc();
    tests++; if (bus.led !== 8'h00) begin fails++; $display("FAIL reset led: got %h expected 00", bus.led); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset busy: got %b expected 0", bus.busy); end
    tests++; if (bus.step !== 1'b0) begin fails++; $display("FAIL reset step: got %b expected 0", bus.step); end
    rst = 1'b0;
    cyc(); cyc();
    tests++; if (bus.busy !== 1'b0 || bus.led !== 8'h00) begin
      fails++; $display("FAIL idle wait: busy=%b led=%h expected 0/00", bus.busy, bus.led);
    end
  endtask

  task automatic test_start();
    start(8'h81, M_ROR);
    tests++; if (bus.led !== 8'h81) begin fails++; $display("FAIL start load: got %h expected 81", bus.led); end
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL start busy: got %b expected 1", bus.busy); end
    tests++; if (bus.step !== 1'b0) begin fails++; $display("FAIL start step on load: got %b expected 0", bus.step); end
    exp_q.push_back(8'hC0); exp_q.push_back(8'h60); exp_q.push_back(8'h30);
    drain("ror", 40, 0);
    stop();
    tests++; if (bus.led !== 8'h00 || bus.busy !== 1'b0) begin
      fails++; $display("FAIL stop: led=%h busy=%b expected 00/0", bus.led, bus.busy);
    end
  endtask

  task automatic test_rol_zero_seed();
    start(8'h00, M_ROL);
    tests++; if (bus.led !== 8'h80) begin fails++; $display("FAIL zero seed load: got %h expected 80", bus.led); end
    exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h04);
    drain("rol", 40, 0);
    stop();
  endtask

  task automatic test_johnson();
    start(8'h01, M_JOHN);
    tests++; if (bus.led !== 8'h01) begin fails++; $display("FAIL john load: got %h expected 01", bus.led); end
    push_model(8'h01, M_JOHN, 16);
    drain("johnson", 200, 0);
    tests++; if (bus.led !== 8'h01) begin fails++; $display("FAIL john period: got %h expected 01", bus.led); end
    stop();
  endtask

  task automatic test_ping();
    logic [7:0] seq [10];
    logic       dirs [10];
    seq  = '{8'h02, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40};
    dirs = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    start(8'h04, M_PING);
    tests++; if (bus.led !== 8'h04) begin fails++; $display("FAIL ping load: got %h expected 04", bus.led); end
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(seq[i]);
      exp_dir_q.push_back(dirs[i]);
    end
    drain("ping", 100, 0);
    stop();
  endtask

  task automatic test_pause_mode();
    int n;
    start(8'h01, M_ROR);
    cyc(); cyc();
    bus.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      tests++;
      if (bus.led !== 8'h01 || bus.step !== 1'b0 || bus.busy !== 1'b1) begin
        fails++;
        $display("FAIL pause hold cycle %0d: led=%h step=%b busy=%b expected 01/0/1", i, bus.led, bus.step, bus.busy);
      end
    end
    bus.en = 1'b1;
    n = 0;
    while (bus.step !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    // Two counts remained before the pause; the resume cycle itself does not count.
    tests++; if (n !== DIV - 2 + 1) begin fails++; $display("FAIL resume latency: got %0d expected %0d", n, DIV - 1); end
    tests++; if (bus.led !== 8'h80) begin fails++; $display("FAIL resume step led: got %h expected 80", bus.led); end
    cyc();
    bus.mode = M_ROL;
    exp_q.push_back(8'h01);
    drain("mode switch", 20, 1);
    stop();
  endtask

  task automatic test_clr_priority();
    start(8'h81, M_ROR);
    cyc(); cyc(); cyc();
    bus.clr = 1'b1;
    cyc();
    tests++; if (bus.led !== 8'h00) begin fails++; $display("FAIL clr led: got %h expected 00", bus.led); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL clr busy: got %b expected 0", bus.busy); end
    tests++; if (bus.step !== 1'b0) begin fails++; $display("FAIL clr step: got %b expected 0", bus.step); end
    bus.clr = 1'b0;
    bus.en  = 1'b0;
    cyc();
    tests++; if (bus.led !== 8'h00 || bus.step !== 1'b0) begin
      fails++; $display("FAIL after clr: led=%h step=%b expected 00/0", bus.led, bus.step);
    end
  endtask

  task automatic test_async_reset();
    start(8'h81, M_ROR);
    cyc(); cyc();
    #2;
    rst = 1'b1;
    #1;
    tests++; if (bus.led !== 8'h00) begin fails++; $display("FAIL async rst led: got %h expected 00", bus.led); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL async rst busy: got %b expected 0", bus.busy); end
    bus.en = 1'b0;
    cyc();
    rst = 1'b0;
    cyc(); cyc();
    tests++; if (bus.busy !== 1'b0 || bus.led !== 8'h00) begin
      fails++; $display("FAIL post-rst wait: busy=%b led=%h expected 0/00", bus.busy, bus.led);
    end
    bus.en = 1'b1;
    cyc();
    tests++; if (bus.led !== 8'h81) begin fails++; $display("FAIL post-rst restart: got %h expected 81", bus.led); end
    stop();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_start();
    test_rol_zero_seed();
    test_johnson();
    test_ping();
    test_pause_mode();
    test_clr_priority();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
